bus_uart_tx: RTL

Downstream consumer of the 64-bit sample bus and its `set1` word-complete strobe. Captures each completed word of eight 8-bit samples and transmits it as eight UART 8N1 frames, sample 1 (`bus_in[7:0]`) first. A one-deep holding buffer absorbs a second word that arrives while a transmission is in progress. Overflow beyond that is dropped and flagged.

---
 rtl/bus_uart_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: captures 64-bit sample words on the rising edge of the set1
// strobe and transmits each word as eight UART 8N1 frames, byte 0 first.
// A one-deep holding register absorbs a word that arrives mid-message; a
// further word is dropped and flagged with a one-cycle overrun pulse.
module bus_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        fastclk,
  input  logic        reset,
  input  logic        set1,
  input  logic [63:0] bus_in,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic          set1_q;
  logic          hold_valid;
  logic [63:0]   shift_reg;
  logic [63:0]   hold_reg;

  logic          capture;
  logic          baud_last;
  logic          msg_done;
  logic          load_new;
  logic          hold_to_shift;
  logic          take_hold;
  logic          drop_word;
  logic [2:0]    next_bit;

  // A message completes on the last cycle of the eighth stop bit; a capture
  // on that same edge is treated as if the transmitter were already free.
  assign capture       = set1 & ~set1_q;
  assign baud_last     = (baud == BAUD_LAST);
  assign msg_done      = (state == STOP) & baud_last & (byte_idx == 3'd7);
  assign load_new      = capture & ((state == IDLE) | (msg_done & ~hold_valid));
  assign hold_to_shift = msg_done & hold_valid;
  assign take_hold     = capture & (state != IDLE) &
                         ((~msg_done & ~hold_valid) | (msg_done & hold_valid));
  assign drop_word     = capture & (state != IDLE) & ~msg_done & hold_valid;
  assign next_bit      = bit_idx + 3'd1;

  // Word storage: no reset needed, validity is tracked by the control path.
  always_ff @(posedge fastclk) begin
    if (load_new) begin
      shift_reg <= bus_in;
    end else if (hold_to_shift) begin
      shift_reg <= hold_reg;
    end
    if (take_hold) begin
      hold_reg <= bus_in;
    end
  end

  // Strobe edge detect, holding-register bookkeeping and the serialiser FSM.
  always_ff @(posedge fastclk) begin
    if (!reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      hold_valid <= 1'b0;
      set1_q     <= 1'b1;
      baud       <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
    end else begin
      set1_q  <= set1;
      overrun <= drop_word;

      if (hold_to_shift) begin
        hold_valid <= capture;
      end else if (take_hold) begin
        hold_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (capture) begin
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
            baud     <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end
        START: begin
          if (baud_last) begin
            baud    <= '0;
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift_reg[{byte_idx, 3'd0}];
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= next_bit;
              tx      <= shift_reg[{byte_idx, next_bit}];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          if (baud_last) begin
            baud <= '0;
            if (byte_idx != 3'd7) begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
              tx       <= 1'b0;
            end else if (hold_valid || capture) begin
              byte_idx <= '0;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              byte_idx <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
